// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU/FPU result stream with a FIFO-buffered UART
// write stream into one register-file write per cycle, signalled by a toggle token.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter bit DROP_R0      = 1'b1
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic        alu_AorF,
    input  logic [4:0]  alu_rw,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        uart_valid,
    input  logic        uart_AorF,
    input  logic [4:0]  uart_rw,
    input  logic [31:0] uart_data,
    output logic        uart_ready,
    output logic        RegWrite,
    output logic        UART_write_enable,
    output logic        distinct,
    output logic        AorF_before,
    output logic [4:0]  rw,
    output logic [31:0] write_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int EW = 38;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } src_e;

    // FIFO entry layout: {AorF, rw[4:0], data[31:0]}
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    src_e          src;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          sel_aorf;
    logic [4:0]    sel_rw;
    logic [31:0]   sel_data;
    logic          drop;
    logic          emit;

    always_comb begin
        fifo_empty = (count == '0);
        push       = uart_valid && uart_ready;
        head       = mem[rd_ptr];

        // A stall cycle always belongs to the FIFO; the ALU holds its request.
        src = SRC_NONE;
        if (alu_stall) begin
            if (!fifo_empty) src = SRC_FIFO;
        end else if (alu_valid) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end
        pop = (src == SRC_FIFO);

        sel_aorf = head[37];
        sel_rw   = head[36:32];
        sel_data = head[31:0];
        if (src == SRC_ALU) begin
            sel_aorf = alu_AorF;
            sel_rw   = alu_rw;
            sel_data = alu_data;
        end

        // Integer r0 writes are consumed silently; f0 is a real register.
        drop = DROP_R0 && !sel_aorf && (sel_rw == 5'd0);
        emit = (src != SRC_NONE) && !drop;

        count_next = count + CW'(push) - CW'(pop);

        starve_next = starve_cnt;
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if ((src == SRC_ALU) && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {uart_AorF, uart_rw, uart_data};
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            starve_cnt        <= '0;
            alu_stall         <= 1'b0;
            uart_ready        <= 1'b1;
            RegWrite          <= 1'b0;
            UART_write_enable <= 1'b0;
            distinct          <= 1'b0;
            AorF_before       <= 1'b0;
            rw                <= '0;
            write_data        <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count      <= count_next;
            uart_ready <= (count_next < CW'(DEPTH));
            starve_cnt <= starve_next;
            // Stall lasts one cycle: the forced pop that follows clears the counter.
            alu_stall  <= (starve_next == SW'(STARVE_LIMIT));

            RegWrite          <= emit && (src == SRC_ALU);
            UART_write_enable <= emit && (src == SRC_FIFO);
            if (emit) begin
                distinct    <= ~distinct;
                AorF_before <= sel_aorf;
                rw          <= sel_rw;
                write_data  <= sel_data;
            end
        end
    end

endmodule
